// File: rtl/demux_pkg.sv
// Shared constants and the helper for the packed-bus offset used by the 1:4 router.
package demux_pkg;
  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  function automatic int unsigned ch_off(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-entry holding register and a wrapping delivery counter.
module demux_slot #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             deliver_i,
  input  logic             flush_i,
  input  logic [W-1:0]     data_i,
  output logic             valid_o,
  output logic [W-1:0]     data_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic             full_q, full_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over delivery so a pass-through refill keeps the slot full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (deliver_i) begin
      full_d = 1'b0;
    end
    if (deliver_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/demux_router.sv
// 1:4 valid/ready router: select decode, in_ready mux and bus packing around four slots.
module demux_router
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [W-1:0]             in_data,
  input  logic                     flush,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*W-1:0]     out_data,
  output logic [NUM_OUT*CNT_W-1:0] cnt
);
  logic               accept;
  logic [NUM_OUT-1:0] load, deliver;

  assign in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid & out_ready;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
    assign load[k] = accept && (in_sel == SEL_W'(k));

    demux_slot #(.W(W), .CNT_W(CNT_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load[k]),
      .deliver_i (deliver[k]),
      .flush_i   (flush),
      .data_i    (in_data),
      .valid_o   (out_valid[k]),
      .data_o    (out_data[ch_off(k, W) +: W]),
      .cnt_o     (cnt[ch_off(k, CNT_W) +: CNT_W])
    );
  end
endmodule

// File: tb/tb_demux_router.sv
// Directed vector table plus hand sequences for streaming, wrap, flush and async reset.
module tb_demux_router;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data, cnt;

  int errors = 0;
  int checks = 0;

  demux_router #(.W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [7:0]  din;
    logic        fl;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
    logic [31:0] od_mask;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] sel, input logic [7:0] din,
                       input logic fl, input logic [3:0] ordy);
    in_valid  = iv;
    in_sel    = sel;
    in_data   = din;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // iv sel din fl ordy | rdy ov od mask cnt
    vt[0] = '{1'b1, 2'd2, 8'hA5, 1'b0, 4'b0000, 1'b1, 4'b0100, 32'h00A50000, 32'hFFFFFFFF, 32'h00000000};
    vt[1] = '{1'b0, 2'd2, 8'hFF, 1'b0, 4'b0000, 1'b0, 4'b0100, 32'h00A50000, 32'hFFFFFFFF, 32'h00000000};
    vt[2] = '{1'b0, 2'd1, 8'hFF, 1'b0, 4'b0000, 1'b1, 4'b0100, 32'h00A50000, 32'hFFFFFFFF, 32'h00000000};
    vt[3] = '{1'b1, 2'd0, 8'h11, 1'b0, 4'b0000, 1'b1, 4'b0101, 32'h00A50011, 32'hFFFFFFFF, 32'h00000000};
    vt[4] = '{1'b1, 2'd3, 8'h33, 1'b0, 4'b0000, 1'b1, 4'b1101, 32'h33A50011, 32'hFFFFFFFF, 32'h00000000};
    vt[5] = '{1'b1, 2'd0, 8'h22, 1'b0, 4'b1001, 1'b1, 4'b0101, 32'h33A50022, 32'hFFFFFFFF, 32'h01000001};
    vt[6] = '{1'b1, 2'd2, 8'h77, 1'b0, 4'b0000, 1'b0, 4'b0101, 32'h33A50022, 32'hFFFFFFFF, 32'h01000001};
    vt[7] = '{1'b1, 2'd1, 8'h55, 1'b1, 4'b0001, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 32'h01000002};
    vt[8] = '{1'b1, 2'd1, 8'h55, 1'b0, 4'b0000, 1'b1, 4'b0010, 32'h00005500, 32'h0000FF00, 32'h01000002};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
    #1;
    chk("reset_ov",  {28'd0, out_valid}, 32'h0);
    chk("reset_od",  out_data, 32'h0);
    chk("reset_cnt", cnt, 32'h0);
    chk("reset_rdy", {31'd0, in_ready}, 32'h1);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].iv, vt[i].sel, vt[i].din, vt[i].fl, vt[i].ordy);
      #1;
      chk($sformatf("v%0d_rdy", i), {31'd0, in_ready}, {31'd0, vt[i].exp_rdy});
      tick();
      chk($sformatf("v%0d_ov", i), {28'd0, out_valid}, {28'd0, vt[i].exp_ov});
      chk($sformatf("v%0d_od", i), out_data & vt[i].od_mask, vt[i].exp_od & vt[i].od_mask);
      chk($sformatf("v%0d_cnt", i), cnt, vt[i].exp_cnt);
    end

    // Streaming pass-through on channel 1: word i-1 leaves while word i enters.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'd1, 8'(i), 1'b0, 4'b0010);
      #1;
      chk($sformatf("st%0d_rdy", i), {31'd0, in_ready}, 32'h1);
      if (i > 0) chk($sformatf("st%0d_dlv", i), {23'd0, out_valid[1], out_data[15:8]}, {23'd0, 1'b1, 8'(i - 1)});
      tick();
    end
    drive(1'b0, 2'd1, 8'h00, 1'b0, 4'b0010);
    #1;
    chk("st_last", {23'd0, out_valid[1], out_data[15:8]}, {23'd0, 1'b1, 8'h09});
    tick();
    chk("st_cnt", cnt, 32'h00000A00);
    chk("st_ov",  {28'd0, out_valid}, 32'h0);

    // 257 deliveries on channel 0 wrap the 8-bit counter to 1.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 2'd0, 8'(i), 1'b0, 4'b0001);
      tick();
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0001);
    tick();
    chk("wrap_cnt", cnt, 32'h00000001);

    // Fill all four, then a one-cycle flush.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'hC0 + 8'(k), 1'b0, 4'b0000);
      tick();
    end
    chk("fill_ov", {28'd0, out_valid}, 32'hF);
    chk("fill_od", out_data, 32'hC3C2C1C0);
    drive(1'b1, 2'd0, 8'hEE, 1'b1, 4'b0000);
    #1;
    chk("flush_rdy", {31'd0, in_ready}, 32'h0);
    tick();
    chk("flush_ov",  {28'd0, out_valid}, 32'h0);
    chk("flush_cnt", cnt, 32'h00000001);

    // Fill again, deliver one, then an asynchronous reset between edges.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'hD0 + 8'(k), 1'b0, 4'b0000);
      tick();
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0100);
    tick();
    chk("pre_rst_cnt", cnt, 32'h00010001);
    chk("pre_rst_ov",  {28'd0, out_valid}, 32'hB);
    drive(1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov",  {28'd0, out_valid}, 32'h0);
    chk("arst_cnt", cnt, 32'h0);
    chk("arst_od",  out_data, 32'h0);
    chk("arst_rdy", {31'd0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1'b1, 2'd3, 8'h9A, 1'b0, 4'b0000);
    tick();
    chk("post_rst_ov", {28'd0, out_valid}, 32'h8);
    chk("post_rst_od", out_data, 32'h9A000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux_router.md
# demux_router

One-to-four routing demultiplexer: accepts a W-bit data word with a 2-bit select on a single valid/ready input stream and delivers it to one of four output channels, each backed by a one-entry holding register. It is the distribution-side counterpart of the team's 4:1 select logic. It sits between a single producer and four independent consumers, and keeps a wrapping delivery counter per channel for status readback.

## Interface
Parameters:
- W, 8, data word width
- CNT_W, 8, width of each per-channel delivery counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer offers a word
- in_ready  output  1  block can take the offered word this cycle
- in_sel  input  2  destination channel, 0..3
- in_data  input  W  word to route
- flush  input  1  synchronous clear of all holding registers
- out_valid  output  4  bit k: channel k holds a word
- out_ready  input  4  bit k: consumer k takes the word
- out_data  output  4*W  channel k occupies bits [k*W +: W]
- cnt  output  4*CNT_W  channel k delivered-word count at [k*CNT_W +: CNT_W]

## Operation
- Each channel k has a slot: full[k] and data[k].
- Input handshake: accept when in_valid && in_ready.
- in_ready = !flush && (!full[in_sel] || out_ready[in_sel]). This is combinational from in_sel, out_ready, the full state and flush. in_ready does not depend on in_valid.
- Output handshake on channel k: a word is delivered when out_valid[k] && out_ready[k]. On delivery, cnt[k] increments by 1 and wraps from 2^CNT_W-1 to 0.
- Slot update per cycle for channel k (flush=0):
  - accept targeting k and delivery on k: data[k] takes in_data, full stays 1 (pass-through refill).
  - accept targeting k, no delivery: data[k] takes in_data, full becomes 1.
  - delivery only: full becomes 0, data[k] holds its value.
  - neither: the slot holds.
- Channels are independent. Deliveries on several channels in the same cycle are all honoured. Only one accept can occur per cycle.
- flush=1:
  - all full bits clear next cycle and data is don't-care.
  - no accept that cycle (in_ready=0).
  - deliveries happening in the flush cycle still increment cnt.
  - counters are not cleared by flush.
- out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
- in_sel and in_data are ignored when in_valid=0.

## Timing
- Reset (rst_n low, asynchronous): full=0, data=0, cnt=0. Therefore out_valid=0, out_data=0, cnt=0, and in_ready=1 when flush=0.
- Release of rst_n is synchronised externally. The first accept can occur on the first clk edge after release.
- Latency: a word accepted at edge N drives out_valid[k]=1 and out_data[k] from edge N onward, so it is visible in the cycle after acceptance.
- Throughput: one word per cycle to the same channel while its consumer holds out_ready=1. One word per cycle overall when alternating channels.
- Back-pressure: when channel k is full and out_ready[k]=0, in_ready=0 for in_sel=k. Other channels are unaffected. There is no head-of-line storage.
- Reset mid-transfer: held words are discarded and counters return to 0. No partial state survives reset.

## Structure
- Shared package demux_pkg:
  - NUM_OUT=4
  - SEL_W=2
  - a function returning the channel slice offset
- Sub-module demux_slot (one per channel, four instances):
  - holds full/data
  - holds the CNT_W delivery counter
  - inputs: load, deliver, flush
  - outputs: valid, data, cnt
- Top level contains only the select decode, the in_ready mux and the bus packing.

## Test plan
- Reset then single routing: in_sel=2, in_data=0xA5, out_ready=0 → next cycle out_valid=4'b0100, channel 2 data=0xA5, and in_ready drops to 0 only when in_sel=2.
- Streaming pass-through: 10 words 0x00..0x09 to channel 1 with out_ready[1]=1 → in_ready stays 1, 10 deliveries in order, cnt[1]=10.
- Simultaneous events: channels 0 and 3 are full and both out_ready are asserted while a new word for channel 0 arrives → both deliver, channel 0 refills, cnt[0] and cnt[3] each increase by 1.
- Counter wrap (CNT_W=8): 257 deliveries on channel 0 → cnt[0]=1.
- Flush and reset mid-operation:
  - Fill all four channels, then assert flush for one cycle → out_valid=0 next cycle, in_ready=0 during flush, counters unchanged.
  - Fill all four channels again, then pulse rst_n low mid-cycle → out_valid and cnt are 0 immediately.
